multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and write-back over multiple clocks, drives the 3-bit ALUOp consumed by the ALU control unit, and uses that unit's JumpRegister flag to resolve `jr`. It sits beside the datapath registers (PC, IR, MDR, A, B, ALUOut) and owns every write enable and mux select in the datapath.

---
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: fetch, decode, execute, memory, write-back.
// Optional memory wait states are enabled by defining MULTICYCLE_MEM_WAIT_EN.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic       Zero,
   input  logic       JumpRegister,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       IllegalOp,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC_R   = 4'd6,
      S_RWB      = 4'd7,
      S_EXEC_I   = 4'd8,
      S_IWB      = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   state_t state, next_state;
   logic   mem_go;

   // Memory handshake: a memory state presents its strobe and holds until
   // MemReady is sampled high; the access completes on that same edge.
`ifdef MULTICYCLE_MEM_WAIT_EN
   assign mem_go = MemReady;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = MemReady;
   assign mem_go = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   assign State = state;

   always_comb begin
      next_state = S_FETCH;
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 2'b00;
      MemtoReg   = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 3'b000;
      PCSource   = 2'b00;
      IllegalOp  = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead    = 1'b1;
            ALUSrcB    = 2'b01;
            ALUOp      = 3'b100;
            IRWrite    = mem_go;
            PCWrite    = mem_go;
            next_state = mem_go ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target is computed here speculatively into ALUOut.
            ALUSrcB = 2'b11;
            ALUOp   = 3'b100;
            case (Opcode)
               OP_LW, OP_SW:              next_state = S_MEMADDR;
               OP_RTYPE:                  next_state = S_EXEC_R;
               OP_ADDI, OP_ORI, OP_ANDI:  next_state = S_EXEC_I;
               OP_BEQ, OP_BNE:            next_state = S_BRANCH;
               OP_J, OP_JAL:              next_state = S_JUMP;
               default: begin
                  IllegalOp  = 1'b1;
                  next_state = S_FETCH;
               end
            endcase
         end
         S_MEMADDR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUOp      = 3'b100;
            next_state = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            MemRead    = 1'b1;
            IorD       = 1'b1;
            next_state = mem_go ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b01;
         end
         S_MEMWRITE: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            next_state = mem_go ? S_FETCH : S_MEMWRITE;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b111;
            if (JumpRegister) begin
               PCWrite  = 1'b1;
               PCSource = 2'b11;
            end else begin
               next_state = S_RWB;
            end
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (Opcode)
               OP_ORI:  ALUOp = 3'b101;
               OP_ANDI: ALUOp = 3'b110;
               default: ALUOp = 3'b100;
            endcase
            next_state = S_IWB;
         end
         S_IWB: begin
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 3'b001;
            PCSource = 2'b01;
            PCWrite  = (Opcode == OP_BNE) ? ~Zero : Zero;
         end
         S_JUMP: begin
            // PC already holds PC+4, which is the JAL link value.
            PCSource = 2'b10;
            PCWrite  = 1'b1;
            if (Opcode == OP_JAL) begin
               RegWrite = 1'b1;
               RegDst   = 2'b10;
               MemtoReg = 2'b10;
            end
         end
         default: next_state = S_FETCH;
      endcase

      if (reset) begin
         PCWrite   = 1'b0;
         IorD      = 1'b0;
         MemRead   = 1'b0;
         MemWrite  = 1'b0;
         IRWrite   = 1'b0;
         RegWrite  = 1'b0;
         RegDst    = 2'b00;
         MemtoReg  = 2'b00;
         ALUSrcA   = 1'b0;
         ALUSrcB   = 2'b00;
         ALUOp     = 3'b000;
         PCSource  = 2'b00;
         IllegalOp = 1'b0;
      end
   end

endmodule
